// File: rtl/hc595_serial_tx_if.sv
// Upstream frame handshake into the 74HC595 serialiser.
interface hc595_serial_tx_if;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       data_valid;
  logic       data_ready;

  modport master (output sel, output seg, output data_valid, input data_ready);
  modport slave  (input sel, input seg, input data_valid, output data_ready);
endinterface

// File: rtl/hc595_serial_tx.sv
// Serialises one {seg, sel} digit frame into two chained 74HC595s and
// pulses the storage latch; owns the stcp/shcp/ds/oe pins.
module hc595_serial_tx #(
  parameter int unsigned SHCP_HALF = 2,
  parameter int unsigned LATCH_CYC = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  hc595_serial_tx_if.slave   up,
  output logic               stcp,
  output logic               shcp,
  output logic               ds,
  output logic               oe
);

  localparam int unsigned PERIOD  = 2 * SHCP_HALF;
  localparam int unsigned PH_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned LC_W    = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
  localparam int unsigned FRAME_W = 14;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e                 state_q, state_d;
  // Bits still to be sent after the one currently on ds; ds itself holds the live bit.
  logic [FRAME_W-2:0]     shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [LC_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic                   ready_q, ready_d;
  logic                   stcp_q, stcp_d;
  logic                   shcp_q, shcp_d;
  logic                   ds_q, ds_d;
  logic                   oe_q, oe_d;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      lat_cnt_q <= '0;
      ready_q   <= 1'b1;
      stcp_q    <= 1'b0;
      shcp_q    <= 1'b0;
      ds_q      <= 1'b0;
      oe_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      lat_cnt_q <= lat_cnt_d;
      ready_q   <= ready_d;
      stcp_q    <= stcp_d;
      shcp_q    <= shcp_d;
      ds_q      <= ds_d;
      oe_q      <= oe_d;
    end
  end

  // Next-state: accept a frame, clock out 14 bits, then hold the latch pulse.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    lat_cnt_d = lat_cnt_q;
    ready_d   = ready_q;
    stcp_d    = stcp_q;
    shcp_d    = shcp_q;
    ds_d      = ds_q;
    oe_d      = oe_q;

    case (state_q)
      IDLE: begin
        if (up.data_valid && ready_q) begin
          shift_d   = {up.seg, up.sel[5:1]};
          ds_d      = up.sel[0];
          shcp_d    = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          phase_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == PH_W'(SHCP_HALF - 1)) begin
          shcp_d = 1'b1;
        end
        if (phase_q == PH_W'(PERIOD - 1)) begin
          phase_d = '0;
          shcp_d  = 1'b0;
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
            stcp_d    = 1'b1;
            lat_cnt_d = '0;
            state_d   = LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            ds_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      LATCH: begin
        if (lat_cnt_q == LC_W'(LATCH_CYC - 1)) begin
          stcp_d  = 1'b0;
          ds_d    = 1'b0;
          ready_d = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign up.data_ready = ready_q;
  assign stcp          = stcp_q;
  assign shcp          = shcp_q;
  assign ds            = ds_q;
  assign oe            = oe_q;

endmodule

// File: tb/tb_hc595_serial_tx.sv
// Directed bench for hc595_serial_tx: default-timing instance and a fast instance.
module tb_hc595_serial_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hc595_serial_tx_if if0 ();
  hc595_serial_tx_if if1 ();

  logic stcp0, shcp0, ds0, oe0;
  logic stcp1, shcp1, ds1, oe1;

  hc595_serial_tx dut0 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .up        (if0),
    .stcp      (stcp0),
    .shcp      (shcp0),
    .ds        (ds0),
    .oe        (oe0)
  );

  hc595_serial_tx #(.SHCP_HALF(1), .LATCH_CYC(1)) dut1 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .up        (if1),
    .stcp      (stcp1),
    .shcp      (shcp1),
    .ds        (ds1),
    .oe        (oe1)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_overlap = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {data_ready, oe, stcp, shcp, ds}
  task automatic sample(input int which, output logic [4:0] v);
    if (which == 0) v = {if0.data_ready, oe0, stcp0, shcp0, ds0};
    else            v = {if1.data_ready, oe1, stcp1, shcp1, ds1};
  endtask

  // Present a frame for one accept edge; returns at the falling edge after it.
  task automatic send(input int which, input logic [5:0] s, input logic [7:0] g, input bit hold);
    if (which == 0) begin
      if0.sel = s; if0.seg = g; if0.data_valid = 1'b1;
    end else begin
      if1.sel = s; if1.seg = g; if1.data_valid = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin
      if0.data_valid = 1'b0;
      if1.data_valid = 1'b0;
    end
  endtask

  logic [13:0] bits;
  int nsh, nst, fsh, stf, stl, rr, rf, ofl;

  // Watch ncyc falling edges; k counts edges after the call (k=1 -> E0+1 when called right after send).
  task automatic collect(input int which, input int ncyc);
    logic [4:0] cur, prev;
    sample(which, prev);
    bits = '0; nsh = 0; nst = 0; fsh = -1; stf = -1; stl = -1; rr = -1; rf = -1; ofl = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      sample(which, cur);
      if (cur[1] && cur[2]) n_overlap++;
      if (cur[1] && !prev[1]) begin
        if (nsh < 14) bits[4'(nsh)] = cur[0];
        if (fsh < 0) fsh = k;
        nsh++;
      end
      if (cur[2]) begin
        if (!prev[2]) nst++;
        if (stf < 0) stf = k;
        stl = k;
      end
      if (cur[4] && !prev[4] && rr < 0) rr = k;
      if (!cur[4] && prev[4] && rf < 0) rf = k;
      if (!cur[3] && prev[3] && ofl < 0) ofl = k;
      prev = cur;
    end
  endtask

  logic [4:0]  v;
  logic [13:0] bits_a;
  int nsh_a, nst_a, rf_a, rr_a, ofl_a, cnt;
  logic        prev_sh;

  initial begin
    rst_n = 1'b0;
    if0.sel = '0; if0.seg = '0; if0.data_valid = 1'b0;
    if1.sel = '0; if1.seg = '0; if1.data_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing toggles.
    collect(0, 6);
    sample(0, v);
    check_eq("rst_ready", 32'(v[4]), 32'd1);
    check_eq("rst_oe",    32'(v[3]), 32'd1);
    check_eq("rst_stcp",  32'(v[2]), 32'd0);
    check_eq("rst_shcp",  32'(v[1]), 32'd0);
    check_eq("rst_ds",    32'(v[0]), 32'd0);
    check_eq("rst_no_shcp", nsh, 0);
    check_eq("rst_no_stcp", nst, 0);
    sample(1, v);
    check_eq("rst1_ready_oe", 32'(v[4:3]), 32'd3);

    // Single frame, default timing.
    send(0, 6'b111110, 8'hC0, 1'b0);
    collect(0, 60);
    check_eq("f1_bits",      32'(bits), 32'(14'b11000000_111110));
    check_eq("f1_nshcp",     nsh, 14);
    check_eq("f1_nstcp",     nst, 1);
    check_eq("f1_first_sh",  fsh, 2);
    check_eq("f1_stcp_from", stf, 56);
    check_eq("f1_stcp_to",   stl, 57);
    check_eq("f1_ready_at",  rr, 58);
    check_eq("f1_oe_fall",   ofl, 58);

    // Back-to-back frames with data_valid held high.
    send(0, 6'b111110, 8'hF9, 1'b1);
    if0.sel = 6'b111101; if0.seg = 8'hA4;
    collect(0, 60);
    bits_a = bits; nsh_a = nsh; nst_a = nst; rf_a = rf; rr_a = rr; ofl_a = ofl;
    if0.data_valid = 1'b0;
    collect(0, 60);
    check_eq("bb_bits_a",   32'(bits_a), 32'(14'b11111001_111110));
    check_eq("bb_bits_b",   32'(bits),   32'(14'b10100100_111101));
    check_eq("bb_nshcp",    nsh_a + nsh, 28);
    check_eq("bb_nstcp",    nst_a + nst, 2);
    check_eq("bb_accept_b", rf_a, 59);
    check_eq("bb_ready_a",  rr_a, 58);
    check_eq("bb_oe_stays", ofl_a, -1);
    check_eq("bb_ready_b",  rr, 57);

    // Reset asserted at the 7th shcp rise.
    send(0, 6'b111110, 8'hC0, 1'b0);
    cnt = 0;
    prev_sh = shcp0;
    for (int k = 0; k < 40 && cnt < 7; k++) begin
      @(negedge clk);
      if (shcp0 && !prev_sh) cnt++;
      prev_sh = shcp0;
    end
    check_eq("mr_reached_7", cnt, 7);
    rst_n = 1'b0;
    @(negedge clk);
    sample(0, v);
    check_eq("mr_outputs", 32'(v), 32'(5'b11000));
    rst_n = 1'b1;
    collect(0, 60);
    check_eq("mr_no_stcp", nst, 0);
    check_eq("mr_no_shcp", nsh, 0);
    send(0, 6'b111101, 8'hA4, 1'b0);
    collect(0, 60);
    check_eq("mr_bits",    32'(bits), 32'(14'b10100100_111101));
    check_eq("mr_nstcp",   nst, 1);
    check_eq("mr_oe_fall", ofl, 58);

    // Fast instance: SHCP_HALF=1, LATCH_CYC=1.
    send(1, 6'b111110, 8'hC0, 1'b0);
    collect(1, 32);
    check_eq("fast_bits",     32'(bits), 32'(14'b11000000_111110));
    check_eq("fast_nshcp",    nsh, 14);
    check_eq("fast_nstcp",    nst, 1);
    check_eq("fast_first_sh", fsh, 1);
    check_eq("fast_stcp_from", stf, 28);
    check_eq("fast_stcp_to",  stl, 28);
    check_eq("fast_ready_at", rr, 29);
    check_eq("fast_oe_fall",  ofl, 29);

    check_eq("shcp_stcp_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
